// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
//   EX->MEM pipeline stage register with a valid/ready handshake and a
//   two-entry skid buffer (main + skid). ex_ready comes straight from a
//   flop, so MEM stalls never form a combinational path back into EX.
//   Entries are delivered in order; flush synchronously kills both entries.
//
// Optional build macro: EX_MEM_PERF_EN adds the CNT_W parameter and the
//   saturating stall_cnt / bubble_cnt performance counters.
//
// Ports:
//   clk             rising-edge clock
//   Reset           asynchronous, active-high reset
//   flush           synchronous kill of all held entries (priority over all)
//   ex_valid        EX presents a valid entry
//   ex_ready        stage can accept (registered, equals !skid_valid)
//   ex_inst/pc/alu_result/store_data, ex_wreg, ex_ctrl   EX payload
//   mem_valid       main register holds a valid entry
//   mem_ready       MEM consumes the entry this cycle
//   mem_inst/pc/alu_result/store_data, mem_wreg          MEM payload
//   mem_ctrl        control bundle, all-zero whenever mem_valid=0
//   stall_cnt       (EX_MEM_PERF_EN) cycles with mem_valid & !mem_ready
//   bubble_cnt      (EX_MEM_PERF_EN) cycles with !mem_valid and no flush
module ex_mem_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 8
`ifdef EX_MEM_PERF_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_inst,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_wreg,
  input  logic [CTRL_W-1:0] ex_ctrl,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_inst,
  output logic [DATA_W-1:0] mem_pc,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_wreg,
  output logic [CTRL_W-1:0] mem_ctrl
`ifdef EX_MEM_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  wreg;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  payload_t ex_in;
  payload_t main_q;
  payload_t skid_q;
  logic     main_valid;
  logic     skid_valid;
  logic     accept;
  logic     consume;

  always_comb begin
    ex_in            = '0;
    ex_in.inst       = ex_inst;
    ex_in.pc         = ex_pc;
    ex_in.alu_result = ex_alu_result;
    ex_in.store_data = ex_store_data;
    ex_in.wreg       = ex_wreg;
    ex_in.ctrl       = ex_ctrl;
  end

  assign ex_ready = ~skid_valid;
  assign accept   = ex_valid & ex_ready;
  assign consume  = main_valid & mem_ready;

  // Main refills from skid first (skid is always the older entry); EX can
  // only land in skid while main is full and not draining.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= ex_in;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= ex_in;
      skid_valid <= 1'b1;
    end
  end

  assign mem_valid      = main_valid;
  assign mem_inst       = main_q.inst;
  assign mem_pc         = main_q.pc;
  assign mem_alu_result = main_q.alu_result;
  assign mem_store_data = main_q.store_data;
  assign mem_wreg       = main_q.wreg;
  // Stale payload may linger after a flush; control must never leak out.
  assign mem_ctrl       = main_valid ? main_q.ctrl : '0;

`ifdef EX_MEM_PERF_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !mem_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (!main_valid && !flush && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        Reset;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_inst, ex_pc, ex_alu_result, ex_store_data;
  logic [4:0]  ex_wreg;
  logic [7:0]  ex_ctrl;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_inst, mem_pc, mem_alu_result, mem_store_data;
  logic [4:0]  mem_wreg;
  logic [7:0]  mem_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic        s_ex_ready, s_mem_valid;
  logic [31:0] s_inst, s_pc, s_alu, s_sd;
  logic [4:0]  s_wreg;
  logic [7:0]  s_ctrl;
  logic [3:0]  s_stall_cnt, s_bubble_cnt;
`endif

  ex_mem_skid_reg #(.DATA_W(32), .REG_W(5), .CTRL_W(8)
`ifdef EX_MEM_PERF_EN
    , .CNT_W(16)
`endif
  ) dut (
    .clk(clk), .Reset(Reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_ctrl(ex_ctrl),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_inst(mem_inst), .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_wreg(mem_wreg), .mem_ctrl(mem_ctrl)
`ifdef EX_MEM_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef EX_MEM_PERF_EN
  // Narrow-counter copy sharing all inputs, used for the saturation case.
  ex_mem_skid_reg #(.DATA_W(32), .REG_W(5), .CTRL_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .Reset(Reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(s_ex_ready),
    .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_ctrl(ex_ctrl),
    .mem_valid(s_mem_valid), .mem_ready(mem_ready),
    .mem_inst(s_inst), .mem_pc(s_pc), .mem_alu_result(s_alu),
    .mem_store_data(s_sd), .mem_wreg(s_wreg), .mem_ctrl(s_ctrl),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );
`endif

  // Payload fields are all derived from pc so an expected pc fixes them.
  function automatic logic [31:0] f_inst(input logic [31:0] pc);
    return pc + 32'h0000_1000;
  endfunction
  function automatic logic [31:0] f_alu(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction
  function automatic logic [31:0] f_sd(input logic [31:0] pc);
    return ~pc;
  endfunction
  function automatic logic [4:0] f_wreg(input logic [31:0] pc);
    return pc[6:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic v, input logic [31:0] pc,
                       input logic [7:0] ctrl, input logic mr);
    flush         = fl;
    ex_valid      = v;
    ex_pc         = pc;
    ex_inst       = f_inst(pc);
    ex_alu_result = f_alu(pc);
    ex_store_data = f_sd(pc);
    ex_wreg       = f_wreg(pc);
    ex_ctrl       = ctrl;
    mem_ready     = mr;
  endtask

  typedef struct {
    logic        fl;
    logic        v;
    logic [31:0] pc;
    logic [7:0]  ctrl;
    logic        mr;
    logic        e_mv;
    logic [31:0] e_pc;
    logic [7:0]  e_ctrl;
    logic        e_er;
  } vec_t;

  vec_t vt[20];

  task automatic check_outputs(input string tag, input logic mv, input logic [31:0] pc,
                               input logic [7:0] ctrl, input logic er);
    chk({tag, ".mem_valid"}, {31'd0, mem_valid}, {31'd0, mv});
    chk({tag, ".ex_ready"},  {31'd0, ex_ready},  {31'd0, er});
    chk({tag, ".mem_ctrl"},  {24'd0, mem_ctrl},  {24'd0, ctrl});
    if (mv) begin
      chk({tag, ".mem_pc"},         mem_pc,         pc);
      chk({tag, ".mem_inst"},       mem_inst,       f_inst(pc));
      chk({tag, ".mem_alu_result"}, mem_alu_result, f_alu(pc));
      chk({tag, ".mem_store_data"}, mem_store_data, f_sd(pc));
      chk({tag, ".mem_wreg"},       {27'd0, mem_wreg}, {27'd0, f_wreg(pc)});
    end
  endtask

  initial begin
    // Expected state after each edge. fl v pc ctrl mr | mv pc ctrl er
    // streaming
    vt[0]  = '{0, 1, 32'h00, 8'h04, 1,  1, 32'h00, 8'h04, 1};
    vt[1]  = '{0, 1, 32'h04, 8'h05, 1,  1, 32'h04, 8'h05, 1};
    vt[2]  = '{0, 1, 32'h08, 8'h06, 1,  1, 32'h08, 8'h06, 1};
    vt[3]  = '{0, 1, 32'h0C, 8'h04, 1,  1, 32'h0C, 8'h04, 1};
    // bubbles
    vt[4]  = '{0, 0, 32'hFF, 8'hFF, 1,  0, 32'h00, 8'h00, 1};
    vt[5]  = '{0, 0, 32'hFF, 8'hFF, 1,  0, 32'h00, 8'h00, 1};
    // backpressure: 0x14 goes to skid, 0x18 held at EX until drained
    vt[6]  = '{0, 1, 32'h10, 8'h01, 1,  1, 32'h10, 8'h01, 1};
    vt[7]  = '{0, 1, 32'h14, 8'h02, 0,  1, 32'h10, 8'h01, 0};
    vt[8]  = '{0, 1, 32'h18, 8'h03, 0,  1, 32'h10, 8'h01, 0};
    vt[9]  = '{0, 1, 32'h18, 8'h03, 1,  1, 32'h14, 8'h02, 1};
    vt[10] = '{0, 1, 32'h18, 8'h03, 1,  1, 32'h18, 8'h03, 1};
    vt[11] = '{0, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 1};
    // flush with both entries full, then flush discarding an accept
    vt[12] = '{0, 1, 32'h20, 8'h07, 0,  1, 32'h20, 8'h07, 1};
    vt[13] = '{0, 1, 32'h24, 8'h07, 0,  1, 32'h20, 8'h07, 0};
    vt[14] = '{1, 1, 32'h28, 8'h07, 0,  0, 32'h00, 8'h00, 1};
    vt[15] = '{1, 1, 32'h2C, 8'h07, 1,  0, 32'h00, 8'h00, 1};
    vt[16] = '{0, 0, 32'h2C, 8'h07, 1,  0, 32'h00, 8'h00, 1};
    vt[17] = '{0, 1, 32'h30, 8'h05, 1,  1, 32'h30, 8'h05, 1};
    vt[18] = '{0, 0, 32'h34, 8'h06, 0,  1, 32'h30, 8'h05, 1};
    vt[19] = '{1, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 1};

    drive(0, 0, 32'h0, 8'h0, 0);
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0, 8'h00, 1'b1);
    chk("reset.mem_pc", mem_pc, 32'h0);
    chk("reset.mem_alu_result", mem_alu_result, 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].fl, vt[i].v, vt[i].pc, vt[i].ctrl, vt[i].mr);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vt[i].e_mv, vt[i].e_pc, vt[i].e_ctrl, vt[i].e_er);
    end

    // Asynchronous reset in the middle of a two-entry stall.
    drive(0, 1, 32'h40, 8'h05, 0);
    @(posedge clk); #1;
    drive(0, 1, 32'h44, 8'h06, 0);
    @(posedge clk); #1;
    check_outputs("stall_pre", 1'b1, 32'h40, 8'h05, 1'b0);
    #2 Reset = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 8'h00, 1'b1);
    chk("async_rst.mem_alu_result", mem_alu_result, 32'h0);
    #1 Reset = 1'b0;
    drive(0, 1, 32'h48, 8'h04, 1);
    @(posedge clk); #1;
    check_outputs("post_rst", 1'b1, 32'h48, 8'h04, 1'b1);

`ifdef EX_MEM_PERF_EN
    // Load one entry (edge sees mem_valid=0: one bubble), stall 5, drain
    // (no count), then 3 bubbles: stall=5, bubble=1+3.
    drive(0, 0, 32'h0, 8'h0, 0);
    Reset = 1'b1; #2 Reset = 1'b0;
    drive(0, 1, 32'h50, 8'h04, 0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 8'h0, 0);
    repeat (5) @(posedge clk);
    #1;
    drive(0, 0, 32'h0, 8'h0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("perf.stall_cnt", {16'd0, stall_cnt}, 32'd5);
    chk("perf.bubble_cnt", {16'd0, bubble_cnt}, 32'd4);
    // 20 stall cycles: narrow counter saturates, wide one keeps counting.
    Reset = 1'b1; #2 Reset = 1'b0;
    drive(0, 1, 32'h60, 8'h04, 0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 8'h0, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("perf4.stall_sat", {28'd0, s_stall_cnt}, 32'd15);
    chk("perf.stall20", {16'd0, stall_cnt}, 32'd20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
